// File: rtl/lsu_store_buffer.sv
// Load/store unit with an in-order posted store buffer in front of data memory.
// Loads forward from the youngest matching buffered store, otherwise read DM; latency 1.
module lsu_store_buffer #(
  parameter int SB_DEPTH = 4,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int DM_AW    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              dm_grant,
  output logic              dm_write_en,
  output logic              dm_read_en,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_data_in,
  input  logic [DATA_W-1:0] dm_data_out,
  output logic              sb_empty,
  output logic              sb_full
);

  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] sb_addr [SB_DEPTH];
  logic [DATA_W-1:0] sb_data [SB_DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;

  logic              store_acc;
  logic              load_acc;
  logic              drain;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [DATA_W-1:0] load_data;
  logic [PW-1:0]     idx;

  assign sb_full  = (count == CW'(SB_DEPTH));
  assign sb_empty = (count == '0);

  // Loads stall while full so a steady load stream cannot starve the drain.
  assign store_acc = !rst && req_valid && req_we && !sb_full;
  assign load_acc  = !rst && req_valid && !req_we && dm_grant && !sb_full;
  assign drain     = !rst && dm_grant && !sb_empty && !load_acc;
  assign req_ready = store_acc || load_acc;

  // Walk oldest to youngest so the last hit is the youngest matching store.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      idx = head + PW'(k);
      if ((CW'(k) < count) && (sb_addr[idx][DM_AW-1:0] == req_addr[DM_AW-1:0])) begin
        fwd_hit  = 1'b1;
        fwd_data = sb_data[idx];
      end
    end
  end

  assign load_data = fwd_hit ? fwd_data : dm_data_out;

  always_comb begin
    dm_write_en = 1'b0;
    dm_read_en  = 1'b0;
    dm_addr     = '0;
    dm_data_in  = '0;
    if (load_acc) begin
      dm_read_en = 1'b1;
      dm_addr    = req_addr;
    end else if (drain) begin
      dm_write_en = 1'b1;
      dm_addr     = sb_addr[head];
      dm_data_in  = sb_data[head];
    end
  end

  always_ff @(posedge clk) begin
    if (store_acc) begin
      sb_addr[tail] <= req_addr;
      sb_data[tail] <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      if (store_acc) tail <= tail + PW'(1);
      if (drain)     head <= head + PW'(1);
      case ({store_acc, drain})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      rsp_valid <= load_acc;
      if (load_acc) rsp_rdata <= load_data;
    end
  end

endmodule

// File: tb/tb_lsu_store_buffer.sv
// Directed bench for lsu_store_buffer: a DM model plus write/response scoreboards
// checked by a monitor on the falling edge.
module tb_lsu_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [15:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid;
  logic [15:0] rsp_rdata;
  logic        dm_grant, dm_write_en, dm_read_en;
  logic [15:0] dm_addr, dm_data_in, dm_data_out;
  logic        sb_empty, sb_full;

  logic [15:0] mem [1024];
  logic [31:0] wq[$];
  logic [15:0] rq[$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  lsu_store_buffer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .dm_grant(dm_grant), .dm_write_en(dm_write_en), .dm_read_en(dm_read_en),
    .dm_addr(dm_addr), .dm_data_in(dm_data_in), .dm_data_out(dm_data_out),
    .sb_empty(sb_empty), .sb_full(sb_full)
  );

  assign dm_data_out = dm_read_en ? mem[dm_addr[9:0]] : 16'hxxxx;

  always @(posedge clk) begin
    if (dm_write_en) mem[dm_addr[9:0]] <= dm_data_in;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every DM write and every response must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rst) begin
      if (dm_write_en) chk("write_in_reset", 32'(dm_write_en), 32'd0);
    end else begin
      if (dm_write_en) begin
        if (wq.size() == 0) chk("unexpected_write", {dm_addr, dm_data_in}, 32'hFFFF_FFFF);
        else chk("dm_write", {dm_addr, dm_data_in}, wq.pop_front());
      end
      if (rsp_valid) begin
        if (rq.size() == 0) chk("unexpected_rsp", 32'(rsp_rdata), 32'hFFFF_FFFF);
        else chk("rsp_rdata", 32'(rsp_rdata), 32'(rq.pop_front()));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [15:0] a, input logic [15:0] d);
    int waited = 0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    @(negedge clk);
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) chk("store_accept_timeout", 32'(req_ready), 32'd1);
    else wq.push_back({a, d});
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] a, input logic [15:0] exp);
    int waited = 0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    @(negedge clk);
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) chk("load_accept_timeout", 32'(req_ready), 32'd1);
    else begin
      chk("load_no_write", 32'(dm_write_en), 32'd0);
      chk("load_read_en", 32'(dm_read_en), 32'd1);
      rq.push_back(exp);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; dm_grant = 1'b0;

    // 1: reset state
    idle(2);
    @(negedge clk);
    chk("rst_sb_empty", 32'(sb_empty), 32'd1);
    chk("rst_sb_full", 32'(sb_full), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_write_en", 32'(dm_write_en), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 2: store then drain on the following cycle
    dm_grant = 1'b1;
    do_store(16'h0005, 16'h1234);
    @(negedge clk);
    chk("t2_drain_write_en", 32'(dm_write_en), 32'd1);
    chk("t2_drain_addr", 32'(dm_addr), 32'd5);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t2_empty_after", 32'(sb_empty), 32'd1);
    chk("t2_idle_addr", 32'(dm_addr), 32'd0);
    @(posedge clk); #1;

    // 3: youngest of two matching stores is forwarded
    dm_grant = 1'b0;
    do_store(16'h0005, 16'h1111);
    do_store(16'h0005, 16'h2222);
    @(negedge clk);
    chk("t3_no_write_nogrant", 32'(dm_write_en), 32'd0);
    @(posedge clk); #1;
    dm_grant = 1'b1;
    do_load(16'h0005, 16'h2222);
    idle(4);
    chk("t3_drained", 32'(sb_empty), 32'd1);
    chk("t3_mem5", 32'(mem[5]), 32'h2222);

    // 4: fill, full backpressure, drain in order
    dm_grant = 1'b0;
    for (int i = 1; i <= 4; i++) do_store(16'(i), 16'hA000 + 16'(i));
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0009; req_wdata = 16'h5555;
    @(negedge clk);
    chk("t4_full", 32'(sb_full), 32'd1);
    chk("t4_fifth_not_ready", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    req_we = 1'b0;
    @(negedge clk);
    chk("t4_load_stall_full", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    dm_grant = 1'b1;
    idle(5);
    chk("t4_empty", 32'(sb_empty), 32'd1);
    do_load(16'h0003, 16'hA003);

    // 5: forwarding compares low DM_AW bits only
    dm_grant = 1'b0;
    do_store(16'h0001, 16'hCAFE);
    dm_grant = 1'b1;
    do_load(16'h0401, 16'hCAFE);
    idle(3);

    // 6: DM read with empty buffer, then reset discards pending stores
    chk("t6_empty", 32'(sb_empty), 32'd1);
    mem[7] = 16'hBEEF;
    do_load(16'h0007, 16'hBEEF);
    idle(2);
    dm_grant = 1'b0;
    do_store(16'h0010, 16'h0001);
    do_store(16'h0011, 16'h0002);
    do_store(16'h0012, 16'h0003);
    rst = 1'b1;
    dm_grant = 1'b1;
    wq.delete();
    idle(1);
    @(negedge clk);
    chk("t6_empty_after_rst", 32'(sb_empty), 32'd1);
    chk("t6_no_write_rst", 32'(dm_write_en), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(4);
    chk("t6_mem10", 32'(mem[16]), 32'd0);
    chk("t6_still_empty", 32'(sb_empty), 32'd1);

    chk("wq_drained", 32'(wq.size()), 32'd0);
    chk("rq_drained", 32'(rq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
